// File: rtl/player_movement_datapath_if.sv
// -----------------------------------------------------------------------------
// player_movement_datapath_if
//   Pixel-plot bus between the player movement datapath and the 160x120,
//   3-bit-colour VGA adapter. One pixel is written per cycle while plot is high.
//
//   x_out   [7:0]  pixel column
//   y_out   [6:0]  pixel row
//   colour  [2:0]  pixel colour
//   plot           write enable for the pixel above
//
//   master : the renderer (drives the bus)
//   slave  : the VGA adapter (consumes the bus)
// -----------------------------------------------------------------------------
interface player_movement_datapath_if;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour;
    logic       plot;

    modport master (output x_out, output y_out, output colour, output plot);
    modport slave  (input  x_out, input  y_out, input  colour, input  plot);
endinterface

// File: rtl/player_movement_datapath.sv
// -----------------------------------------------------------------------------
// player_movement_datapath
//   Owns the player's horizontal position and renders the player sprite.
//   It is driven by the one-hot state flags of the movement control FSM.
//   For each accepted move request it does three things in order:
//   erase the old sprite, step and clamp the position, then redraw the sprite.
//   A single extra request that arrives while a sequence is running is held
//   and run straight after that sequence.
//
// Ports
//   clk                    system clock, posedge
//   reset                  synchronous active-high reset
//   inInputState           FSM waiting for keys (no datapath action)
//   inSetAState            latch direction LEFT (wins over inSetDState)
//   inSetDState            latch direction RIGHT
//   inUpdatePositionState  one-cycle move request
//   player_x     [7:0]     committed sprite left x
//   busy                   erase/move/draw sequence in progress
//   vga                    plot bus to the VGA adapter (master side)
// -----------------------------------------------------------------------------
module player_movement_datapath #(
    parameter int         SCREEN_W      = 160,
    parameter int         PLAYER_W      = 8,
    parameter int         PLAYER_H      = 4,
    parameter int         Y_POS         = 112,
    parameter int         STEP          = 2,
    parameter int         START_X       = 76,
    parameter logic [2:0] PLAYER_COLOUR = 3'b111,
    parameter logic [2:0] BG_COLOUR     = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inInputState,
    input  logic       inSetAState,
    input  logic       inSetDState,
    input  logic       inUpdatePositionState,
    output logic [7:0] player_x,
    output logic       busy,
    player_movement_datapath_if.master vga
);

    localparam int PX_W = (PLAYER_W > 1) ? $clog2(PLAYER_W) : 1;
    localparam int PY_W = (PLAYER_H > 1) ? $clog2(PLAYER_H) : 1;
    localparam logic [PX_W-1:0] PX_LAST = PX_W'(PLAYER_W - 1);
    localparam logic [PY_W-1:0] PY_LAST = PY_W'(PLAYER_H - 1);

    typedef enum logic [2:0] {
        INIT_DRAW,
        IDLE,
        ERASE,
        MOVE,
        DRAW
    } state_t;

    // Next left x after one step. The sum is formed in 9 bits so that
    // x + STEP near the right wall cannot wrap before the clamp compares it.
    function automatic logic [7:0] calc_target(input logic [7:0] x, input logic left);
        logic [8:0] x9;
        logic [8:0] t;
        x9 = {1'b0, x};
        if (left) begin
            t = (x9 < 9'(STEP)) ? 9'd0 : x9 - 9'(STEP);
        end else begin
            t = (x9 > 9'(SCREEN_W - PLAYER_W - STEP)) ? 9'(SCREEN_W - PLAYER_W)
                                                       : x9 + 9'(STEP);
        end
        return 8'(t);
    endfunction

    state_t            state_q, state_d;
    logic              dir_left_q, dir_left_d;
    logic              pending_q, pending_d;
    logic [7:0]        player_x_q, player_x_d;
    logic [7:0]        target_q, target_d;
    logic [PX_W-1:0]   px_q, px_d;
    logic [PY_W-1:0]   py_q, py_d;
    logic              plot_q, plot_d;
    logic [7:0]        x_out_q, x_out_d;
    logic [6:0]        y_out_q, y_out_d;
    logic [2:0]        colour_q, colour_d;
    logic              busy_q, busy_d;

    logic              sweeping;
    logic              sweep_last;
    logic [7:0]        step_target;

    assign sweeping    = (state_q == INIT_DRAW) || (state_q == ERASE) || (state_q == DRAW);
    assign sweep_last  = (px_q == PX_LAST) && (py_q == PY_LAST);
    // Both the IDLE decision and the back-to-back decision at the end of DRAW
    // use the currently latched direction and the committed position.
    assign step_target = calc_target(player_x_q, dir_left_q);

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        dir_left_d = dir_left_q;
        pending_d  = pending_q;
        player_x_d = player_x_q;
        target_d   = target_q;
        px_d       = px_q;
        py_d       = py_q;
        plot_d     = 1'b0;
        x_out_d    = x_out_q;
        y_out_d    = y_out_q;
        colour_d   = colour_q;
        busy_d     = 1'b1;

        if (inSetAState) begin
            dir_left_d = 1'b1;
        end else if (inSetDState) begin
            dir_left_d = 1'b0;
        end

        // Busy-time requests are held one deep; a request while one is
        // already held is simply absorbed.
        if (inUpdatePositionState && (state_q != IDLE)) begin
            pending_d = 1'b1;
        end

        // Row-major sprite sweep: px fastest, counter wraps to 0 on the last
        // pixel so the next sweep always starts at the top-left corner.
        if (sweeping) begin
            plot_d   = 1'b1;
            x_out_d  = player_x_q + 8'(px_q);
            y_out_d  = 7'(Y_POS) + 7'(py_q);
            colour_d = (state_q == ERASE) ? BG_COLOUR : PLAYER_COLOUR;
            if (px_q == PX_LAST) begin
                px_d = '0;
                py_d = sweep_last ? '0 : py_q + 1'b1;
            end else begin
                px_d = px_q + 1'b1;
            end
        end

        unique case (state_q)
            INIT_DRAW: begin
                if (sweep_last) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                busy_d = 1'b0;
                // A request held over from INIT_DRAW is served here as well.
                if (inUpdatePositionState || pending_q) begin
                    pending_d = 1'b0;
                    // At a wall the step is a no-op: nothing is redrawn.
                    if (step_target != player_x_q) begin
                        target_d = step_target;
                        state_d  = ERASE;
                    end
                end
            end
            ERASE: begin
                if (sweep_last) begin
                    state_d = MOVE;
                end
            end
            MOVE: begin
                player_x_d = target_q;
                state_d    = DRAW;
            end
            DRAW: begin
                if (sweep_last) begin
                    state_d = IDLE;
                    if (pending_q || inUpdatePositionState) begin
                        pending_d = 1'b0;
                        if (step_target != player_x_q) begin
                            target_d = step_target;
                            state_d  = ERASE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= INIT_DRAW;
            dir_left_q <= 1'b0;
            pending_q  <= 1'b0;
            player_x_q <= 8'(START_X);
            target_q   <= 8'(START_X);
            px_q       <= '0;
            py_q       <= '0;
            plot_q     <= 1'b0;
            x_out_q    <= '0;
            y_out_q    <= '0;
            colour_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_left_q <= dir_left_d;
            pending_q  <= pending_d;
            player_x_q <= player_x_d;
            target_q   <= target_d;
            px_q       <= px_d;
            py_q       <= py_d;
            plot_q     <= plot_d;
            x_out_q    <= x_out_d;
            y_out_q    <= y_out_d;
            colour_q   <= colour_d;
            busy_q     <= busy_d;
        end
    end

    assign player_x   = player_x_q;
    assign busy       = busy_q;
    assign vga.x_out  = x_out_q;
    assign vga.y_out  = y_out_q;
    assign vga.colour = colour_q;
    assign vga.plot   = plot_q;

    // The movement FSM is one-hot, so at most one of its flags is high.
    a_flags_onehot0: assert property (@(posedge clk) disable iff (reset)
        $onehot0({inInputState, inSetAState, inSetDState, inUpdatePositionState}));

endmodule

// File: tb/tb_player_movement_datapath.sv
// -----------------------------------------------------------------------------
// tb_player_movement_datapath
//   Directed scenarios followed by random stimulus. A transaction-level model
//   expands each accepted move into its expected per-cycle output stream
//   (erase sweep, move cycle, draw sweep) and compares every cycle.
// -----------------------------------------------------------------------------
module tb_player_movement_datapath;

    localparam int SCREEN_W = 160;
    localparam int PLAYER_W = 8;
    localparam int PLAYER_H = 4;
    localparam int Y_POS    = 112;
    localparam int STEP     = 2;
    localparam int START_X  = 76;
    localparam int C_PLAYER = 7;
    localparam int C_BG     = 0;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_input, in_a, in_d, in_upd;
    logic [7:0] player_x;
    logic       busy;

    player_movement_datapath_if vga_if ();

    player_movement_datapath dut (
        .clk                   (clk),
        .reset                 (reset),
        .inInputState          (in_input),
        .inSetAState           (in_a),
        .inSetDState           (in_d),
        .inUpdatePositionState (in_upd),
        .player_x              (player_x),
        .busy                  (busy),
        .vga                   (vga_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit plot;
        int x;
        int y;
        int colour;
        bit busy;
        int px;
        bit rst;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_cur;
    int   m_x;
    bit   m_left;
    bit   m_pend;
    bit   m_is_move;

    function automatic int next_x(input int x, input bit left);
        if (left) return (x < STEP) ? 0 : x - STEP;
        return (x + STEP > SCREEN_W - PLAYER_W) ? SCREEN_W - PLAYER_W : x + STEP;
    endfunction

    task automatic push_sweep(input int x, input int col);
        for (int py = 0; py < PLAYER_H; py++)
            for (int px = 0; px < PLAYER_W; px++)
                exp_q.push_back('{1'b1, x + px, Y_POS + py, col, 1'b1, x, 1'b0});
    endtask

    // Try one move from the model position; a wall makes it a no-op.
    task automatic try_move();
        int t;
        t = next_x(m_x, m_left);
        if (t != m_x) begin
            push_sweep(m_x, C_BG);
            exp_q.push_back('{1'b0, 0, 0, 0, 1'b1, t, 1'b0});
            push_sweep(t, C_PLAYER);
            m_x       = t;
            m_is_move = 1'b1;
        end
    endtask

    task automatic model(input bit r, input bit a, input bit d, input bit u);
        if (r) begin
            exp_q.delete();
            m_x       = START_X;
            m_left    = 1'b0;
            m_pend    = 1'b0;
            exp_cur   = '{1'b0, 0, 0, 0, 1'b0, START_X, 1'b1};
            push_sweep(START_X, C_PLAYER);
            m_is_move = 1'b0;
            return;
        end
        if (exp_q.size() == 0) begin
            exp_cur = '{1'b0, 0, 0, 0, 1'b0, m_x, 1'b0};
            if (u || m_pend) begin
                m_pend = 1'b0;
                try_move();
            end
        end else begin
            exp_cur = exp_q.pop_front();
            if (u) m_pend = 1'b1;
            if (exp_q.size() == 0 && m_is_move && m_pend) begin
                m_pend = 1'b0;
                try_move();
            end
        end
        if (a) m_left = 1'b1;
        else if (d) m_left = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    task automatic step(input bit r, input bit a, input bit d, input bit u);
        reset    = r;
        in_a     = a;
        in_d     = d;
        in_upd   = u;
        in_input = !(a || d || u);
        @(posedge clk);
        model(r, a, d, u);
        @(negedge clk);
        check("plot", vga_if.plot, exp_cur.plot);
        check("busy", busy, exp_cur.busy);
        check("player_x", player_x, exp_cur.px);
        if (exp_cur.plot || exp_cur.rst) begin
            check("x_out", vga_if.x_out, exp_cur.x);
            check("y_out", vga_if.y_out, exp_cur.y);
            check("colour", vga_if.colour, exp_cur.colour);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        while (busy && k < 300) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            k++;
        end
        check("wait_idle_timeout", busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r;

        // 1: reset and initial draw
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(40);
        check("init_x", player_x, START_X);

        // 2: single right move, busy length
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n = 0;
        for (int i = 0; i < 80; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (busy) n++;
        end
        check("busy_len", n, 2 * PLAYER_W * PLAYER_H + 1);
        check("x_after_right", player_x, START_X + STEP);

        // 3: walk to the left wall, then a no-op request
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 45; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            wait_idle();
        end
        check("left_wall_x", player_x, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("left_wall_noplot", vga_if.plot, 1'b0);
        check("left_wall_notbusy", busy, 1'b0);

        // 4: walk to the right wall, then a no-op request
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 80; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            wait_idle();
        end
        check("right_wall_x", player_x, SCREEN_W - PLAYER_W);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("right_wall_noplot", vga_if.plot, 1'b0);
        check("right_wall_notbusy", busy, 1'b0);

        // 5: pending request runs back to back; a third is dropped
        step(1'b0, 1'b1, 1'b0, 1'b0);
        n = 0;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin step(1'b0, 1'b0, 1'b0, 1'b0); if (busy) n++; end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        if (busy) n++;
        for (int i = 0; i < 10; i++) begin step(1'b0, 1'b0, 1'b0, 1'b0); if (busy) n++; end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        if (busy) n++;
        for (int i = 0; i < 150; i++) begin step(1'b0, 1'b0, 1'b0, 1'b0); if (busy) n++; end
        check("b2b_busy_len", n, 2 * (2 * PLAYER_W * PLAYER_H + 1));
        check("b2b_x", player_x, SCREEN_W - PLAYER_W - 2 * STEP);

        // 6: reset in the middle of DRAW
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(40);
        check("mid_draw_busy", busy, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("reset_plot", vga_if.plot, 1'b0);
        check("reset_x", player_x, START_X);
        idle(40);
        check("after_reset_x", player_x, START_X);

        // random stimulus
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 999));
            if (r < 3)        step(1'b1, 1'b0, 1'b0, 1'b0);
            else if (r < 40)  step(1'b0, 1'b1, 1'b0, 1'b0);
            else if (r < 80)  step(1'b0, 1'b0, 1'b1, 1'b0);
            else if (r < 115) step(1'b0, 1'b0, 1'b0, 1'b1);
            else              step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        idle(150);
        check("final_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/player_movement_datapath.md
Name: player_movement_datapath

Overview:
- Datapath/renderer driven by the player movement control FSM. It consumes that FSM's one-hot state flags and owns the player's horizontal position.
- On each position update it erases the old sprite, steps and clamps the position, then redraws the sprite.
- It drives the 160x120, 3-bit-colour VGA adapter plot interface and sits between the movement FSM and the VGA adapter in the top level.

Parameters:
- SCREEN_W, 160, screen width in pixels
- PLAYER_W, 8, sprite width in pixels
- PLAYER_H, 4, sprite height in pixels
- Y_POS, 112, fixed top row of the sprite
- STEP, 2, pixels moved per update
- START_X, 76, x position after reset
- PLAYER_COLOUR, 3'b111, sprite colour
- BG_COLOUR, 3'b000, erase colour

Ports:
- clk  input  1  system clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- inInputState  input  1  FSM is idle waiting for keys; no datapath action
- inSetAState  input  1  latch direction = LEFT
- inSetDState  input  1  latch direction = RIGHT
- inUpdatePositionState  input  1  request one move in the latched direction
- player_x  output  8  current committed sprite left x
- x_out  output  8  VGA pixel x
- y_out  output  7  VGA pixel y
- colour  output  3  VGA pixel colour
- plot  output  1  VGA write enable, one pixel per cycle
- busy  output  1  erase/move/draw sequence in progress

Behaviour:
- Reset (reset=1 at a posedge):
  - State goes to INIT_DRAW.
  - player_x=START_X, dir=RIGHT, pending=0.
  - plot=0, x_out=0, y_out=0, colour=0, busy=0 while reset is held.
- All outputs are registered.
- Direction register:
  - inSetAState -> LEFT; inSetDState -> RIGHT.
  - If both are high, inSetAState wins.
  - Updated in any internal state.
- Internal states: INIT_DRAW, IDLE, ERASE, MOVE, DRAW.
- Pixel counter (px 0..PLAYER_W-1, py 0..PLAYER_H-1):
  - px is fastest; sweep is row-major.
  - Each cycle in ERASE/DRAW/INIT_DRAW: plot=1, x_out=player_x+px, y_out=Y_POS+py.
  - Sweep length is PLAYER_W*PLAYER_H cycles (32 at defaults).
- INIT_DRAW:
  - Draws the sprite at START_X with colour=PLAYER_COLOUR, busy=1.
  - Goes to IDLE when done. An update request arriving here sets pending.
- IDLE:
  - plot=0, busy=0.
  - On inUpdatePositionState=1, capture op_dir=dir and compute the target:
    - LEFT: player_x<STEP ? 0 : player_x-STEP.
    - RIGHT: player_x>SCREEN_W-PLAYER_W-STEP ? SCREEN_W-PLAYER_W : player_x+STEP.
  - If target==player_x (sprite at a wall), stay in IDLE: no plot, busy stays 0.
  - Otherwise go to ERASE; busy=1 and the first erase pixel appear on the next cycle.
- ERASE: full sweep at the old player_x with colour=BG_COLOUR, then MOVE.
- MOVE:
  - One cycle, plot=0, busy=1; player_x<=target.
  - Clamp arithmetic is done in 9 bits; the result is never outside 0..SCREEN_W-PLAYER_W.
- DRAW:
  - Full sweep at the new player_x with colour=PLAYER_COLOUR.
  - Then, if pending=1: clear pending, recompute the target from the current dir, and apply the same equality check as IDLE. Go to ERASE if the target differs, else IDLE.
  - If pending=0: go to IDLE.
- Request while busy:
  - inUpdatePositionState=1 in INIT_DRAW/ERASE/MOVE/DRAW sets pending=1.
  - Pending is one deep; extra requests while pending=1 are dropped.
  - The FSM's update flag lasts exactly one cycle, so each request is one event.
- Latency and duration:
  - Request at posedge N -> busy=1 and first plot at N+1.
  - busy stays high for 2*PLAYER_W*PLAYER_H+1 cycles (65 at defaults), then deasserts.
- Reset mid-operation: the sequence aborts immediately, pending clears, and the sprite is redrawn via INIT_DRAW. Stale pixels left on screen are the top level's responsibility.
- inInputState is ignored apart from documentation/assertions; at most one of the four flags is expected high per cycle.

Test Plan:
1. Release reset -> 32 plot cycles, colour=7, x=76..83, y=112..115, row-major; then busy=0, player_x=76.
2. Pulse inSetDState then inUpdatePositionState -> 32 erase pixels (colour=0, x 76..83), 1 MOVE cycle with plot=0, 32 draw pixels (colour=7, x 78..85); busy high exactly 65 cycles; player_x=78.
3. Three LEFT updates from player_x=3 (STEP=2) -> player_x goes 1, 0, then the third request produces no plot and busy stays 0.
4. RIGHT updates from player_x=151 -> 152 (clamped), then the next request yields no plot.
5. Two update pulses 10 cycles apart during one sequence, plus a third pulse -> exactly two full sequences back to back (130 busy cycles); the third pulse is dropped.
6. Assert reset midway through DRAW -> plot=0 next cycle and pending cleared; after release, INIT_DRAW at x=76.
